kuznechik_block_feeder: RTL and testbench
=========================================

# kuznechik_block_feeder

Upstream front-end for `kuznechik_cipher`. It packs an incoming byte stream into 128-bit blocks and pads the final partial block. It runs the cipher's request/busy/valid/ack handshake on each block and presents the ciphered block on a 128-bit valid/ready output. Exactly one block is in flight at a time.

## Interface
Parameters:
- `PAD_BYTE`, default `8'h00`: fill value for unused bytes of a block closed by `s_last_i`.
- `CNT_W`, default `16`: width of the processed-block counter.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `s_data_i` in 8: input byte.
- `s_valid_i` in 1: input byte valid.
- `s_last_i` in 1: byte is the last of the message; closes the block.
- `s_ready_o` out 1: feeder accepts a byte this cycle.
- `cph_data_o` out 128: plaintext block to cipher `data_i`.
- `cph_request_o` out 1: to cipher `request_i`.
- `cph_ack_o` out 1: to cipher `ack_i`.
- `cph_data_i` in 128: from cipher `data_o`.
- `cph_valid_i` in 1: from cipher `valid_o`.
- `cph_busy_i` in 1: from cipher `busy_o`.
- `m_data_o` out 128: ciphered block.
- `m_last_o` out 1: block was closed by `s_last_i`.
- `m_valid_o` out 1: output block valid.
- `m_ready_i` in 1: downstream accepts the block.
- `blk_cnt_o` out `CNT_W`: number of blocks delivered; wraps modulo 2^`CNT_W`.

## Operation
- FSM states and transitions:
  - `COLLECT`: `s_ready_o`=1. Each handshake (`s_valid_i`&`s_ready_o`) writes the byte to slot `idx`, where byte 0 → `[127:120]` and byte 15 → `[7:0]`, then does `idx`+1.
    - If `idx`==15, or `s_last_i` is set, go to `ISSUE`.
    - `m_last_o` is latched to `s_last_i` of the closing byte.
  - `ISSUE`: wait for `cph_busy_i`==0. In the cycle it is seen low, register `cph_request_o`=1 (high for exactly one cycle) and go to `WAIT`.
  - `WAIT`: when `cph_valid_i`=1, capture `cph_data_i` into the output register, register `cph_ack_o`=1 (exactly one cycle) and go to `OUT`.
  - `OUT`: `m_valid_o`=1. On `m_ready_i`, do `blk_cnt_o`+1, preset the block buffer to `PAD_BYTE` in all slots, set `idx`=0 and go to `COLLECT`.
- Padding: the buffer is preset to `PAD_BYTE` on reset and on every return to `COLLECT`. A block closed by `s_last_i` at `idx`=k keeps slots k+1..15 at `PAD_BYTE`. `s_last_i` at `idx`=15 closes a full block with no padding.
- Zero-length messages do not exist: `s_last_i` is only meaningful with `s_valid_i`.
- `cph_data_o` is driven directly from the block buffer. It is stable from entry to `ISSUE` until exit from `WAIT`.
- `cph_valid_i` is ignored outside `WAIT`. `cph_busy_i` is ignored outside `ISSUE`.
- `m_data_o` and `m_last_o` are held stable while `m_valid_o`&!`m_ready_i`.
- `s_ready_o`=0 in every state except `COLLECT`. Bytes presented at any other time stall; none are dropped.

## Timing
- Reset values: state `COLLECT`, `idx`=0, buffer all `PAD_BYTE`.
  - Outputs: `s_ready_o`=1, `cph_request_o`=0, `cph_ack_o`=0, `m_valid_o`=0, `m_last_o`=0, `m_data_o`=0, `blk_cnt_o`=0. `cph_data_o` equals the buffer, so it is all `PAD_BYTE`.
- Reset is synchronous and active-high, and wins over every other event in the same cycle. Reset mid-block discards the partial block and any in-flight result. The cipher is reset by the same system reset.
- Latencies, with the closing byte accepted at edge N:
  - `ISSUE` is entered at N+1.
  - With `cph_busy_i`=0, `cph_request_o` is high in cycle N+1→N+2.
  - `cph_ack_o` is high the cycle after `cph_valid_i` is sampled high.
  - `m_valid_o` rises in the same cycle `cph_ack_o` rises.
- Back-to-back: `s_ready_o` reasserts the cycle after the `m_valid_o`&`m_ready_i` handshake. Minimum overhead between blocks is 1 cycle plus cipher latency.

## Structure
- Package `kuznechik_pkg`:
  - `typedef logic [127:0] block_t`
  - `BLOCK_BYTES`=16
  - FSM state enum `feeder_state_t` (`COLLECT`, `ISSUE`, `WAIT`, `OUT`)
- One natural sub-module: `kuznechik_byte_packer`, containing the buffer, `idx` and the `PAD_BYTE` preset. The FSM and the cipher handshake stay in the top module.

## Test plan
- Full block:
  - Stimulus: 16 bytes `69 b7 … 76 b5`, last on byte 16, cipher model with busy=0 and valid after 10 cycles.
  - Required: `cph_data_o`=`128'h69b7dcb452e20d03a7008f242b0276b5`, `cph_request_o` and `cph_ack_o` each exactly 1 cycle, `m_last_o`=1, `blk_cnt_o`=1.
- Partial block:
  - Stimulus: 3 bytes `AA BB CC` with last, `PAD_BYTE`=`8'h00`.
  - Required: `cph_data_o`=`128'hAABBCC000…0` (13 zero bytes).
- Busy stall:
  - Stimulus: hold `cph_busy_i`=1 for 20 cycles after the block closes.
  - Required: `cph_request_o` stays 0 throughout, pulses once after busy falls, and `cph_data_o` is unchanged.
- Output backpressure:
  - Stimulus: `m_ready_i`=0 for 8 cycles.
  - Required: `m_data_o` is stable, `s_ready_o`=0 and no input byte is accepted.
  - Then: a 1-cycle `m_ready_i` → `s_ready_o`=1 the next cycle.
- Multi-block:
  - Stimulus: 11 back-to-back 16-byte blocks.
  - Required: 11 results delivered in input order, `blk_cnt_o`=11, `m_last_o` only on block 11.
- Reset mid-`WAIT`:
  - Stimulus: assert `rst_i` for 1 cycle.
  - Required: all outputs at reset values the next cycle, and a late `cph_valid_i` is ignored with no `cph_ack_o`.

Source files
------------

// File: rtl/kuznechik_pkg.sv
// Shared types and constants for the Kuznechik block feeder.
package kuznechik_pkg;

  typedef logic [127:0] block_t;

  localparam int BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    OUT     = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/kuznechik_byte_packer.sv
// Byte-to-block packer: holds the 16-byte block buffer and the write index.
// Byte 0 lands in [127:120], byte 15 in [7:0]; unused slots keep PAD_BYTE.
module kuznechik_byte_packer
  import kuznechik_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       wr_en,
  input  logic [7:0] wr_byte,
  input  logic       clear,
  output block_t     block,
  output logic [3:0] idx
);

  logic [7:0] slot_reg [BLOCK_BYTES];
  logic [3:0] idx_reg;

  // Buffer slots: preset to the pad value on reset/clear, else write the addressed slot.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      for (int i = 0; i < BLOCK_BYTES; i++) begin
        slot_reg[i] <= PAD_BYTE;
      end
    end else if (wr_en) begin
      slot_reg[idx_reg] <= wr_byte;
    end
  end

  // Write index: restarts at slot 0 for every new block.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      idx_reg <= 4'd0;
    end else if (wr_en) begin
      idx_reg <= idx_reg + 4'd1;
    end
  end

  // Big-endian slot mapping onto the 128-bit block.
  for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_slot_map
    assign block[127-8*gi -: 8] = slot_reg[gi];
  end

  assign idx = idx_reg;

endmodule

// File: rtl/kuznechik_block_feeder.sv
// Front-end for kuznechik_cipher: packs bytes into padded 128-bit blocks,
// runs the request/busy/valid/ack handshake, and presents the result on a
// valid/ready output. One block in flight at a time.
module kuznechik_block_feeder
  import kuznechik_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       s_data_i,
  input  logic             s_valid_i,
  input  logic             s_last_i,
  output logic             s_ready_o,
  output logic [127:0]     cph_data_o,
  output logic             cph_request_o,
  output logic             cph_ack_o,
  input  logic [127:0]     cph_data_i,
  input  logic             cph_valid_i,
  input  logic             cph_busy_i,
  output logic [127:0]     m_data_o,
  output logic             m_last_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [CNT_W-1:0] blk_cnt_o
);

  feeder_state_t    state_reg;
  logic             request_reg;
  logic             ack_reg;
  logic             m_valid_reg;
  logic             m_last_reg;
  block_t           m_data_reg;
  logic [CNT_W-1:0] blk_cnt_reg;

  logic   accept;
  logic   clear;
  logic   closing;
  block_t block;
  logic [3:0] idx;

  assign s_ready_o = (state_reg == COLLECT);
  assign accept    = s_valid_i && s_ready_o;
  assign closing   = (idx == 4'd15) || s_last_i;
  // Output handshake completes the block: buffer goes back to all-pad.
  assign clear     = (state_reg == OUT) && m_ready_i;

  kuznechik_byte_packer #(
    .PAD_BYTE(PAD_BYTE)
  ) u_packer (
    .clk    (clk_i),
    .srst   (rst_i),
    .wr_en  (accept),
    .wr_byte(s_data_i),
    .clear  (clear),
    .block  (block),
    .idx    (idx)
  );

  // Feeder FSM with registered handshake pulses and output block register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= COLLECT;
      request_reg <= 1'b0;
      ack_reg     <= 1'b0;
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
      m_data_reg  <= '0;
      blk_cnt_reg <= '0;
    end else begin
      request_reg <= 1'b0;
      ack_reg     <= 1'b0;
      case (state_reg)
        COLLECT: begin
          if (accept && closing) begin
            m_last_reg <= s_last_i;
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          if (!cph_busy_i) begin
            request_reg <= 1'b1;
            state_reg   <= WAIT;
          end
        end
        WAIT: begin
          if (cph_valid_i) begin
            m_data_reg  <= cph_data_i;
            ack_reg     <= 1'b1;
            m_valid_reg <= 1'b1;
            state_reg   <= OUT;
          end
        end
        OUT: begin
          if (m_ready_i) begin
            m_valid_reg <= 1'b0;
            blk_cnt_reg <= blk_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            state_reg   <= COLLECT;
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

  assign cph_data_o    = block;
  assign cph_request_o = request_reg;
  assign cph_ack_o     = ack_reg;
  assign m_data_o      = m_data_reg;
  assign m_last_o      = m_last_reg;
  assign m_valid_o     = m_valid_reg;
  assign blk_cnt_o     = blk_cnt_reg;

endmodule

// File: tb/tb_kuznechik_block_feeder.sv
// Self-checking bench for kuznechik_block_feeder with a simple cipher model.
module tb_kuznechik_block_feeder;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [127:0] cph_data_o;
  logic         cph_request;
  logic         cph_ack;
  logic [127:0] cph_data_i;
  logic         cph_valid;
  logic         cph_busy;
  logic [127:0] m_data;
  logic         m_last;
  logic         m_valid;
  logic         m_ready;
  logic [15:0]  blk_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;
  int exp_req = 0;

  always #5 clk = ~clk;

  kuznechik_block_feeder #(.PAD_BYTE(8'h00), .CNT_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .s_data_i     (s_data),
    .s_valid_i    (s_valid),
    .s_last_i     (s_last),
    .s_ready_o    (s_ready),
    .cph_data_o   (cph_data_o),
    .cph_request_o(cph_request),
    .cph_ack_o    (cph_ack),
    .cph_data_i   (cph_data_i),
    .cph_valid_i  (cph_valid),
    .cph_busy_i   (cph_busy),
    .m_data_o     (m_data),
    .m_last_o     (m_last),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .blk_cnt_o    (blk_cnt)
  );

  // Stand-in cipher transform: swap halves and xor a constant.
  function automatic logic [127:0] cmodel(input logic [127:0] x);
    return {x[63:0], x[127:64]} ^ 128'h5A5A_A5A5_0F0F_F0F0_1234_5678_9ABC_DEF0;
  endfunction

  // Cipher model: valid one cycle, about 10 cycles after a request is seen.
  logic [127:0] held;
  int           cd = 0;
  int           model_valids = 0;
  always @(posedge clk) begin
    cph_valid <= 1'b0;
    if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        cph_valid  <= 1'b1;
        cph_data_i <= cmodel(held);
        model_valids <= model_valids + 1;
      end
    end
    if (cph_request) begin
      held <= cph_data_o;
      cd   <= 10;
    end
  end

  // Pulse-width monitor for request and ack.
  logic req_prev = 1'b0, ack_prev = 1'b0;
  int   req_pulses = 0, double_req = 0, double_ack = 0;
  always @(negedge clk) begin
    if (cph_request && req_prev) double_req++;
    if (cph_ack && ack_prev) double_ack++;
    if (cph_request && !req_prev) req_pulses++;
    req_prev = cph_request;
    ack_prev = cph_ack;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [127:0] msg, input int n, input logic last);
    int t;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = msg[127-8*i -: 8];
      s_last  = last && (i == n - 1);
      t = 0;
      while (!s_ready && t < 200) begin
        step();
        t++;
      end
      if (t >= 200) chk("s_ready_timeout", 128'(s_ready), 128'd1);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic wait_mvalid();
    int t = 0;
    while (!m_valid && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) chk("m_valid_timeout", 128'(m_valid), 128'd1);
  endtask

  task automatic run_block(input string tag, input logic [127:0] msg, input int n,
                           input logic last, input logic [127:0] exp_blk);
    send_block(msg, n, last);
    exp_req++;
    chk({tag, "_issue_sready"}, 128'(s_ready), 128'd0);
    chk({tag, "_issue_req0"}, 128'(cph_request), 128'd0);
    step();
    chk({tag, "_req1"}, 128'(cph_request), 128'd1);
    chk({tag, "_cph_data"}, cph_data_o, exp_blk);
    wait_mvalid();
    chk({tag, "_ack_with_mvalid"}, 128'(cph_ack), 128'd1);
    chk({tag, "_m_data"}, m_data, cmodel(exp_blk));
    chk({tag, "_m_last"}, 128'(m_last), 128'(last));
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    exp_cnt++;
    chk({tag, "_sready_after"}, 128'(s_ready), 128'd1);
    chk({tag, "_blk_cnt"}, 128'(blk_cnt), 128'(exp_cnt));
    chk({tag, "_mvalid_low"}, 128'(m_valid), 128'd0);
  endtask

  typedef struct {
    logic [127:0] msg;
    int           n;
    logic         last;
    logic [127:0] exp_blk;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [127:0] msg;
    int bad;

    vecs[0] = '{128'h69b7dcb452e20d03a7008f242b0276b5, 16, 1'b1, 128'h69b7dcb452e20d03a7008f242b0276b5};
    vecs[1] = '{128'hAABBCCDEADBEEFDEADBEEFDEADBEEF77, 3, 1'b1, {24'hAABBCC, 104'h0}};
    vecs[2] = '{128'h000102030405060708090A0B0C0D0EFF, 15, 1'b1, 128'h000102030405060708090A0B0C0D0E00};
    vecs[3] = '{128'h0123456789ABCDEFFEDCBA9876543210, 16, 1'b0, 128'h0123456789ABCDEFFEDCBA9876543210};
    vecs[4] = '{128'h11FFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 1, 1'b1, {8'h11, 120'h0}};

    rst = 1'b1; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
    cph_busy = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    chk("rst_s_ready", 128'(s_ready), 128'd1);
    chk("rst_req", 128'(cph_request), 128'd0);
    chk("rst_ack", 128'(cph_ack), 128'd0);
    chk("rst_m_valid", 128'(m_valid), 128'd0);
    chk("rst_m_last", 128'(m_last), 128'd0);
    chk("rst_m_data", m_data, 128'd0);
    chk("rst_blk_cnt", 128'(blk_cnt), 128'd0);
    chk("rst_cph_data", cph_data_o, 128'd0);

    // Table-driven blocks
    for (int v = 0; v < 5; v++) begin
      run_block($sformatf("vec%0d", v), vecs[v].msg, vecs[v].n, vecs[v].last, vecs[v].exp_blk);
    end

    // Busy stall: request held off for 20 cycles, data stable
    cph_busy = 1'b1;
    send_block(128'hDEADBEEFCAFE99999999999999999999, 6, 1'b1);
    exp_req++;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (cph_request) bad++;
      if (cph_data_o !== {48'hDEADBEEFCAFE, 80'h0}) bad++;
      step();
    end
    chk("busy_no_req_data_stable", 128'(bad), 128'd0);
    cph_busy = 1'b0;
    step();
    chk("busy_req_pulse", 128'(cph_request), 128'd1);
    step();
    chk("busy_req_single", 128'(cph_request), 128'd0);
    wait_mvalid();
    chk("busy_m_data", m_data, cmodel({48'hDEADBEEFCAFE, 80'h0}));
    m_ready = 1'b1; step(); m_ready = 1'b0; exp_cnt++;

    // Output backpressure with a byte waiting upstream
    send_block(128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 16, 1'b0);
    exp_req++;
    wait_mvalid();
    s_valid = 1'b1; s_data = 8'h99; s_last = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (m_data !== cmodel(128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0)) bad++;
      if (s_ready || !m_valid) bad++;
    end
    chk("bp_stable_no_accept", 128'(bad), 128'd0);
    s_valid = 1'b0; s_last = 1'b0;
    m_ready = 1'b1; step(); m_ready = 1'b0; exp_cnt++;
    chk("bp_sready_next", 128'(s_ready), 128'd1);
    chk("bp_blk_cnt", 128'(blk_cnt), 128'(exp_cnt));
    run_block("after_bp", 128'h55EEEEEEEEEEEEEEEEEEEEEEEEEEEEEE, 1, 1'b1, {8'h55, 120'h0});

    // Eleven back-to-back full blocks, last only on the final one
    for (int k = 0; k < 11; k++) begin
      for (int i = 0; i < 16; i++) msg[127-8*i -: 8] = 8'(k * 16 + i + 8'h30);
      run_block($sformatf("multi%0d", k), msg, 16, k == 10, msg);
    end

    // Reset while waiting for the cipher
    send_block(128'hFEEDFACE00112233445566778899AABB, 5, 1'b1);
    exp_req++;
    step(); step();
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_s_ready", 128'(s_ready), 128'd1);
    chk("mid_rst_req", 128'(cph_request), 128'd0);
    chk("mid_rst_ack", 128'(cph_ack), 128'd0);
    chk("mid_rst_m_valid", 128'(m_valid), 128'd0);
    chk("mid_rst_m_last", 128'(m_last), 128'd0);
    chk("mid_rst_m_data", m_data, 128'd0);
    chk("mid_rst_blk_cnt", 128'(blk_cnt), 128'd0);
    chk("mid_rst_cph_data", cph_data_o, 128'd0);
    begin
      int v0;
      v0 = model_valids;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
        step();
        if (cph_ack || m_valid || !s_ready) bad++;
      end
      chk("late_valid_seen", 128'(model_valids - v0), 128'd1);
      chk("late_valid_ignored", 128'(bad), 128'd0);
    end

    chk("req_pulse_count", 128'(req_pulses), 128'(exp_req));
    chk("req_single_cycle", 128'(double_req), 128'd0);
    chk("ack_single_cycle", 128'(double_ack), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
